pipelined_datapath: RTL
=======================

// Module: pipelined_datapath
// PURPOSE
//  Three-stage (ISSUE -> EX -> WB) parametrised successor of the single-cycle regfile/ALU/RAM datapath.
//  Accepts one micro-op per clock: register file read with forwarding, ALU with status flags, word RAM,
//  and write-back of ALU or RAM data.
//  Adds hazard detection with an in_valid/in_ready stall and a hard-wired zero register.
//  Driven by the future control unit or directly by a bench.
// PARAMETERS
//  DATA_W     64   datapath width (power of 2, >=8)
//  REG_CNT    32   register count; index REG_CNT-1 is ZR (reads 0, writes dropped)
//  SEL_W      5    register select width, $clog2(REG_CNT)
//  RAM_DEPTH  256  RAM words; address = ALU result[$clog2(RAM_DEPTH)-1:0], wraps by truncation
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       async active-high; clears regfile, pipeline, flags
//  in_valid     in   1       micro-op present this cycle
//  in_ready     out  1       combinational; 0 = load-use stall, micro-op not taken
//  A_sel        in   SEL_W   operand A register
//  B_sel        in   SEL_W   operand B register; also the store-data register
//  D_sel        in   SEL_W   destination register
//  reg_wrt      in   1       write D at WB
//  K            in   DATA_W  constant operand
//  B_is_K       in   1       ALU operand B = K instead of reg[B_sel]
//  FS           in   5       {A_inv, B_inv, op[2:0]}: op 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR
//  C0           in   1       ADD carry-in
//  RAM_wrt      in   1       store reg[B_sel] at address ALU result, end of EX
//  wb_from_ram  in   1       WB data = RAM read data (load) instead of ALU result
//  out_valid    out  1       WB stage holds a valid micro-op
//  ALU_out      out  DATA_W  WB ALU result
//  RAM_out      out  DATA_W  WB RAM read data
//  status       out  4       {V,C,N,Z} of WB micro-op; holds last value when out_valid=0
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, ALU_out=0, RAM_out=0, status=0, all regs=0; EX/WB valids cleared.
//    An in-flight store in EX is dropped. RAM contents are not reset.
//  - Issue at posedge when in_valid&in_ready: EX regs load fwd(A), opB (K or fwd(B)), fwd(B) store data, controls.
//    A stalled or idle cycle inserts a bubble (ex_valid=0).
//  - EX: ALU is combinational on EX regs. A_inv/B_inv invert operands before op.
//    LSL/LSR shift by opB[$clog2(DATA_W)-1:0].
//  - EX posedge: if RAM_wrt, RAM[addr] <= store data; synchronous RAM read of addr.
//    Read-during-write returns the new data. WB regs load result, RAM data, flags.
//  - Flags: Z = (res==0); N = res[DATA_W-1]; C/V = ADD carry-out/signed overflow; C=V=0 for other ops.
//  - WB: out_valid=1 for one cycle; if reg_wrt and D!=ZR, reg[D] <= (wb_from_ram ? RAM_out : ALU_out) at posedge.
//    Latency issue->out_valid = 2 cycles; throughput 1/clk without hazards.
//  - fwd(x): x==ZR -> 0; else EX match (ex_valid, reg_wrt, !wb_from_ram) -> EX ALU result;
//    else WB match -> WB data; else regfile.
//    EX has priority over WB; same-cycle WB write + read is covered by the WB match.
//  - in_ready = !(ex_valid & ex_reg_wrt & ex_wb_from_ram & ex_D!=ZR & (A_sel==ex_D | B_sel==ex_D)).
//    B_sel is compared even when B_is_K because B_sel carries the store data.
//    Exactly one stall cycle per load-use; a held in_valid is taken on the next cycle.
//  - Reset deasserting mid-stream: the first posedge after release may issue.
// STRUCTURE
//  - datapath_pkg: FS op localparams (OP_AND..OP_LSR), FS bit indices, status bit indices (ST_Z=0..ST_V=3),
//    function is_zr(sel).
//  - Sub-module alu_core (combinational: a, b, FS, C0 -> res, flags), reused by the ALU unit tests.
//  - Regfile, RAM, forwarding and hazard logic stay inline.
// TESTING
//  1. Reset mid-flight (two ops in EX/WB) -> out_valid=0, status=0, store not committed, all regs read 0.
//  2. X1 = ZR + K (K=7364, ADD, B_is_K) -> out_valid 2 clk later, ALU_out=7364, status=0000.
//  3. Next cycle X2 = X1 + X1 -> EX forward, no stall, ALU_out=14728.
//  4. STUR X1 at [ZR+5]; LDUR X3 <- [ZR+5]; ADD X4 = X3 + X1 back-to-back
//     -> in_ready=0 for exactly 1 clk, RAM_out=7364, X4=14728.
//  5. 0x7FFF_FFFF_FFFF_FFFF + 1 -> {V,C,N,Z}=1010; 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0101;
//     LSL 1 by 63 -> 0x8000_0000_0000_0000, N=1.
//  6. Write 0x55 to X31 then ADD X5 = X31 + X31 -> ALU_out=0, Z=1; address 0x105 aliases word 5.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the pipelined datapath: ALU op codes, FS bit
// positions, status bit positions and the zero-register test.
package datapath_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;

  localparam int FS_A_INV = 4;
  localparam int FS_B_INV = 3;
  localparam int FS_OP_HI = 2;
  localparam int FS_OP_LO = 0;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  // The highest register index is the hard-wired zero register.
  function automatic logic is_zr(input int sel, input int reg_cnt);
    return sel == reg_cnt - 1;
  endfunction

endpackage

// File: rtl/pipelined_datapath_alu_core.sv
// Combinational ALU: optional operand inversion, logic/add/shift ops and
// {V,C,N,Z} flags. Carry and overflow are only meaningful for ADD.
module alu_core
  import datapath_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        FS,
  input  logic              C0,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flags
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] a_eff;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [SH_W-1:0]   sh_amt;

  // Operand conditioning, op select and flag generation
  always_comb begin
    a_eff  = FS[FS_A_INV] ? ~a : a;
    b_eff  = FS[FS_B_INV] ? ~b : b;
    sum    = {1'b0, a_eff} + {1'b0, b_eff} + {{DATA_W{1'b0}}, C0};
    sh_amt = b_eff[SH_W-1:0];
    res    = '0;
    flags  = '0;
    case (FS[FS_OP_HI:FS_OP_LO])
      OP_AND: res = a_eff & b_eff;
      OP_OR:  res = a_eff | b_eff;
      OP_ADD: begin
        res         = sum[DATA_W-1:0];
        flags[ST_C] = sum[DATA_W];
        flags[ST_V] = (a_eff[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (res[DATA_W-1] != a_eff[DATA_W-1]);
      end
      OP_XOR: res = a_eff ^ b_eff;
      OP_LSL: res = a_eff << sh_amt;
      OP_LSR: res = a_eff >> sh_amt;
      default: res = '0;
    endcase
    flags[ST_Z] = (res == '0);
    flags[ST_N] = res[DATA_W-1];
  end

endmodule

// File: rtl/pipelined_datapath.sv
// Three-stage ISSUE -> EX -> WB datapath: register file with EX/WB
// forwarding, ALU, word RAM with synchronous read, and a one-cycle
// load-use stall. The top register index always reads as zero.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int REG_CNT   = 32,
  parameter int SEL_W     = 5,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  A_sel,
  input  logic [SEL_W-1:0]  B_sel,
  input  logic [SEL_W-1:0]  D_sel,
  input  logic              reg_wrt,
  input  logic [DATA_W-1:0] K,
  input  logic              B_is_K,
  input  logic [4:0]        FS,
  input  logic              C0,
  input  logic              RAM_wrt,
  input  logic              wb_from_ram,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] RAM_out,
  output logic [3:0]        status
);

  localparam int ADDR_W = $clog2(RAM_DEPTH);

  logic [DATA_W-1:0] rf_q  [REG_CNT];
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic              ex_valid_q, ex_reg_wrt_q, ex_wb_ram_q, ex_ram_wrt_q, ex_c0_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_st_q;
  logic [SEL_W-1:0]  ex_d_q;
  logic [4:0]        ex_fs_q;

  logic              out_valid_q, wb_reg_wrt_q, wb_from_ram_q;
  logic [DATA_W-1:0] wb_alu_q, wb_ram_q;
  logic [3:0]        wb_st_q;
  logic [SEL_W-1:0]  wb_d_q;

  logic [DATA_W-1:0] ex_res, wb_data, fwd_a, fwd_b, op_b_d;
  logic [3:0]        ex_flags;
  logic [ADDR_W-1:0] ex_addr;
  logic              ex_fwd_ok, wb_fwd_ok, stall, issue;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a     (ex_a_q),
    .b     (ex_b_q),
    .FS    (ex_fs_q),
    .C0    (ex_c0_q),
    .res   (ex_res),
    .flags (ex_flags)
  );

  assign ex_addr   = ex_res[ADDR_W-1:0];
  assign wb_data   = wb_from_ram_q ? wb_ram_q : wb_alu_q;
  // A load in EX has no data yet, so it is never a forwarding source.
  assign ex_fwd_ok = ex_valid_q & ex_reg_wrt_q & ~ex_wb_ram_q;
  assign wb_fwd_ok = out_valid_q & wb_reg_wrt_q;

  // Operand fetch: zero register, then youngest producer first
  always_comb begin
    fwd_a = rf_q[A_sel];
    fwd_b = rf_q[B_sel];
    if (is_zr(int'(A_sel), REG_CNT))            fwd_a = '0;
    else if (ex_fwd_ok && (A_sel == ex_d_q))    fwd_a = ex_res;
    else if (wb_fwd_ok && (A_sel == wb_d_q))    fwd_a = wb_data;
    if (is_zr(int'(B_sel), REG_CNT))            fwd_b = '0;
    else if (ex_fwd_ok && (B_sel == ex_d_q))    fwd_b = ex_res;
    else if (wb_fwd_ok && (B_sel == wb_d_q))    fwd_b = wb_data;
    op_b_d = B_is_K ? K : fwd_b;
  end

  // B_sel is checked even for K operands because it also names the store data.
  assign stall    = ex_valid_q & ex_reg_wrt_q & ex_wb_ram_q &
                    ~is_zr(int'(ex_d_q), REG_CNT) &
                    ((A_sel == ex_d_q) | (B_sel == ex_d_q));
  assign in_ready = ~stall;
  assign issue    = in_valid & ~stall;

  // ISSUE -> EX register; a stalled or idle cycle becomes a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_reg_wrt_q <= 1'b0;
      ex_wb_ram_q  <= 1'b0;
      ex_ram_wrt_q <= 1'b0;
      ex_c0_q      <= 1'b0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_st_q      <= '0;
      ex_d_q       <= '0;
      ex_fs_q      <= '0;
    end else begin
      ex_valid_q <= issue;
      if (issue) begin
        ex_reg_wrt_q <= reg_wrt;
        ex_wb_ram_q  <= wb_from_ram;
        ex_ram_wrt_q <= RAM_wrt;
        ex_c0_q      <= C0;
        ex_a_q       <= fwd_a;
        ex_b_q       <= op_b_d;
        ex_st_q      <= fwd_b;
        ex_d_q       <= D_sel;
        ex_fs_q      <= FS;
      end
    end
  end

  // RAM store; contents survive reset, and reset clears ex_valid so a pending store is lost
  always_ff @(posedge clock) begin
    if (ex_valid_q && ex_ram_wrt_q) ram_q[ex_addr] <= ex_st_q;
  end

  // EX -> WB register; outputs hold their last value across bubbles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      wb_reg_wrt_q  <= 1'b0;
      wb_from_ram_q <= 1'b0;
      wb_alu_q      <= '0;
      wb_ram_q      <= '0;
      wb_st_q       <= '0;
      wb_d_q        <= '0;
    end else begin
      out_valid_q <= ex_valid_q;
      if (ex_valid_q) begin
        wb_reg_wrt_q  <= ex_reg_wrt_q;
        wb_from_ram_q <= ex_wb_ram_q;
        wb_alu_q      <= ex_res;
        wb_ram_q      <= ex_ram_wrt_q ? ex_st_q : ram_q[ex_addr];
        wb_st_q       <= ex_flags;
        wb_d_q        <= ex_d_q;
      end
    end
  end

  // Register file write-back; writes to the zero register are dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else if (out_valid_q && wb_reg_wrt_q && !is_zr(int'(wb_d_q), REG_CNT)) begin
      rf_q[wb_d_q] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_out   = wb_alu_q;
  assign RAM_out   = wb_ram_q;
  assign status    = wb_st_q;

endmodule
